// File: rtl/fileio_ctrl_pkg.sv
// Shared definitions for the file-I/O sequencer: state encoding, register map and bus payload.
package fileio_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_WRITE = 3'd1,
        ST_POLL  = 3'd2,
        ST_READ  = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    localparam int unsigned STATUS_OFS     = 0;
    localparam int unsigned DATA_OFS       = 2;
    localparam int unsigned DATA_READY_BIT = 0;
    localparam logic [1:0]  DATA_BE        = 2'b01;

    typedef struct packed {
        logic        en;
        logic [13:0] addr;
        logic [1:0]  we;
        logic [15:0] din;
    } per_bus_t;

    // Byte base + byte offset -> peripheral word address
    function automatic logic [13:0] word_addr(input logic [14:0] base, input int unsigned ofs);
        return 14'((base + 15'(ofs)) >> 1);
    endfunction

endpackage

// File: rtl/fileio_ctrl_rr_arb.sv
// Round-robin pick: first set request after rr_last, wrapping; purely combinational.
module fileio_ctrl_rr_arb #(
    parameter int unsigned NREQ = 2
) (
    input  logic [NREQ-1:0]         req,
    input  logic [$clog2(NREQ)-1:0] rr_last,
    output logic [NREQ-1:0]         gnt,
    output logic [$clog2(NREQ)-1:0] gnt_idx,
    output logic                    any
);

    localparam int unsigned IW = $clog2(NREQ);

    always_comb begin
        int unsigned cand;
        gnt     = '0;
        gnt_idx = '0;
        any     = 1'b0;
        cand    = 0;
        for (int unsigned off = 1; off <= NREQ; off++) begin
            cand = (32'(rr_last) + off) % NREQ;
            if (!any && req[IW'(cand)]) begin
                any              = 1'b1;
                gnt_idx          = IW'(cand);
                gnt[IW'(cand)]   = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fileio_ctrl.sv
// Shares the file-I/O peripheral between NREQ byte requesters: arbitrates, then runs
// put (DATA write) or get (STATUS poll + DATA read) bus cycles.
module fileio_ctrl
    import fileio_ctrl_pkg::*;
#(
    parameter int unsigned NREQ      = 2,
    parameter logic [14:0] BASE_ADDR = 15'h00c0,
    parameter int unsigned POLL_MAX  = 16
) (
    input  logic                mclk,
    input  logic                puc_rst_n,
    input  logic [NREQ-1:0]     req_valid,
    input  logic [NREQ-1:0]     req_write,
    input  logic [8*NREQ-1:0]   req_wdata,
    output logic [NREQ-1:0]     req_done,
    output logic [7:0]          rsp_rdata,
    output logic                rsp_err,
    output logic                bus_req,
    input  logic                bus_gnt,
    output logic                per_en,
    output logic [13:0]         per_addr,
    output logic [1:0]          per_we,
    output logic [15:0]         per_din,
    input  logic [15:0]         per_dout
);

    localparam int unsigned IW = $clog2(NREQ);
    localparam int unsigned PW = $clog2(POLL_MAX) + 1;
    localparam logic [13:0] STATUS_WADDR = word_addr(BASE_ADDR, STATUS_OFS);
    localparam logic [13:0] DATA_WADDR   = word_addr(BASE_ADDR, DATA_OFS);
    localparam logic [PW-1:0] POLL_LAST  = PW'(POLL_MAX - 1);

    state_t          state_q, state_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic [IW-1:0]   rr_last_q, rr_last_d;
    logic [7:0]      wdata_q, wdata_d;
    logic [7:0]      rdata_q, rdata_d;
    logic            err_q, err_d;
    logic [PW-1:0]   poll_q, poll_d;
    logic [NREQ-1:0] arb_gnt;
    logic [IW-1:0]   arb_idx;
    logic            arb_any;
    per_bus_t        bus_c;
    logic [7:0]      unused_dout_hi;

    assign unused_dout_hi = per_dout[15:8];

    fileio_ctrl_rr_arb #(.NREQ(NREQ)) u_arb (
        .req     (req_valid),
        .rr_last (rr_last_q),
        .gnt     (arb_gnt),
        .gnt_idx (arb_idx),
        .any     (arb_any)
    );

    always_ff @(posedge mclk or negedge puc_rst_n) begin
        if (!puc_rst_n) begin
            state_q   <= ST_IDLE;
            idx_q     <= '0;
            rr_last_q <= IW'(NREQ - 1);
            wdata_q   <= '0;
            rdata_q   <= '0;
            err_q     <= 1'b0;
            poll_q    <= '0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            rr_last_q <= rr_last_d;
            wdata_q   <= wdata_d;
            rdata_q   <= rdata_d;
            err_q     <= err_d;
            poll_q    <= poll_d;
        end
    end

    // Next state and bus cycle; bus fields follow state and grant so reset drops them at once
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        rr_last_d = rr_last_q;
        wdata_d   = wdata_q;
        rdata_d   = rdata_q;
        err_d     = err_q;
        poll_d    = poll_q;
        bus_c     = '0;
        bus_req   = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (arb_any) begin
                    idx_d   = arb_idx;
                    wdata_d = req_wdata[{arb_idx, 3'b000} +: 8];
                    poll_d  = '0;
                    state_d = (|(req_write & arb_gnt)) ? ST_WRITE : ST_POLL;
                end
            end
            ST_WRITE: begin
                bus_req = 1'b1;
                if (bus_gnt) begin
                    bus_c.en   = 1'b1;
                    bus_c.addr = DATA_WADDR;
                    bus_c.we   = DATA_BE;
                    bus_c.din  = {8'h00, wdata_q};
                    rdata_d    = '0;
                    err_d      = 1'b0;
                    state_d    = ST_DONE;
                end
            end
            ST_POLL: begin
                bus_req = 1'b1;
                if (bus_gnt) begin
                    bus_c.en   = 1'b1;
                    bus_c.addr = STATUS_WADDR;
                    if (per_dout[DATA_READY_BIT]) begin
                        state_d = ST_READ;
                    end else if (poll_q == POLL_LAST) begin
                        rdata_d = '0;
                        err_d   = 1'b1;
                        state_d = ST_DONE;
                    end else begin
                        poll_d = poll_q + PW'(1);
                    end
                end
            end
            ST_READ: begin
                bus_req = 1'b1;
                if (bus_gnt) begin
                    bus_c.en   = 1'b1;
                    bus_c.addr = DATA_WADDR;
                    rdata_d    = per_dout[7:0];
                    err_d      = 1'b0;
                    state_d    = ST_DONE;
                end
            end
            ST_DONE: begin
                rr_last_d = idx_q;
                state_d   = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign per_en   = bus_c.en;
    assign per_addr = bus_c.addr;
    assign per_we   = bus_c.we;
    assign per_din  = bus_c.din;

    // Completion outputs decode straight from flops
    assign req_done  = (state_q == ST_DONE) ? (NREQ'(1) << idx_q) : '0;
    assign rsp_rdata = (state_q == ST_DONE) ? rdata_q : 8'h00;
    assign rsp_err   = (state_q == ST_DONE) ? err_q : 1'b0;

endmodule

// File: tb/tb_fileio_ctrl.sv
// Directed and randomized bench for fileio_ctrl with a scripted file-I/O peripheral model.
module tb_fileio_ctrl;

    localparam int unsigned NREQ     = 2;
    localparam int unsigned POLL_MAX = 16;
    localparam logic [13:0] STATUS_W = 14'h0060;
    localparam logic [13:0] DATA_W   = 14'h0061;

    logic              mclk = 1'b0;
    logic              puc_rst_n;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_write;
    logic [8*NREQ-1:0] req_wdata;
    logic [NREQ-1:0]   req_done;
    logic [7:0]        rsp_rdata;
    logic              rsp_err;
    logic              bus_req;
    logic              bus_gnt;
    logic              per_en;
    logic [13:0]       per_addr;
    logic [1:0]        per_we;
    logic [15:0]       per_din;
    logic [15:0]       per_dout;

    int total = 0;
    int bad   = 0;
    int model_last = NREQ - 1;

    // Peripheral model state: monitor owns the counters, stimulus owns the script
    int          st_cnt = 0, rd_cnt = 0, wr_cnt = 0, en_cnt = 0;
    logic [15:0] wr_din = '0;
    int          st_base = 0;
    int          zeros = 0;
    logic [7:0]  dat = '0;

    always #5 mclk = ~mclk;

    fileio_ctrl #(.NREQ(NREQ), .BASE_ADDR(15'h00c0), .POLL_MAX(POLL_MAX)) dut (
        .mclk      (mclk),
        .puc_rst_n (puc_rst_n),
        .req_valid (req_valid),
        .req_write (req_write),
        .req_wdata (req_wdata),
        .req_done  (req_done),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .bus_req   (bus_req),
        .bus_gnt   (bus_gnt),
        .per_en    (per_en),
        .per_addr  (per_addr),
        .per_we    (per_we),
        .per_din   (per_din),
        .per_dout  (per_dout)
    );

    // STATUS reports ready once 'zeros' not-ready reads have been served
    assign per_dout = (per_addr == STATUS_W) ? {15'd0, ((st_cnt - st_base) >= zeros)} :
                      (per_addr == DATA_W)   ? {8'hA5, dat} : 16'hDEAD;

    always @(posedge mclk) begin
        if (per_en && bus_gnt) begin
            en_cnt = en_cnt + 1;
            if (per_addr == DATA_W && per_we == 2'b01) begin
                wr_cnt = wr_cnt + 1;
                wr_din = per_din;
            end else if (per_addr == STATUS_W && per_we == 2'b00) begin
                st_cnt = st_cnt + 1;
            end else if (per_addr == DATA_W && per_we == 2'b00) begin
                rd_cnt = rd_cnt + 1;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int rr_pick(input int last, input logic [NREQ-1:0] v);
        for (int o = 1; o <= NREQ; o++) begin
            if (v[(last + o) % NREQ]) return (last + o) % NREQ;
        end
        return 0;
    endfunction

    // One transaction from an IDLE negedge; returns at the negedge of the following IDLE cycle
    task automatic run_txn(input logic [NREQ-1:0] vec, input logic [NREQ-1:0] wr,
                           input logic [8*NREQ-1:0] wd, input int z, input logic [7:0] d,
                           input int stall_len, input string tag);
        int g, exp_lat, exp_st, exp_rd, exp_wr, cycles, sb, rb, wb, eb;
        bit exp_err, done_seen;
        logic [NREQ-1:0] done_v;
        g = rr_pick(model_last, vec);
        zeros = z; dat = d; st_base = st_cnt;
        sb = st_cnt; rb = rd_cnt; wb = wr_cnt; eb = en_cnt;
        req_valid = vec; req_write = wr; req_wdata = wd; bus_gnt = 1'b1;
        if (wr[g]) begin
            exp_lat = 2; exp_st = 0; exp_rd = 0; exp_wr = 1; exp_err = 1'b0;
        end else if (z < POLL_MAX) begin
            exp_lat = z + 3; exp_st = z + 1; exp_rd = 1; exp_wr = 0; exp_err = 1'b0;
        end else begin
            exp_lat = POLL_MAX + 1; exp_st = POLL_MAX; exp_rd = 0; exp_wr = 0; exp_err = 1'b1;
        end
        exp_lat += stall_len;
        cycles = 0; done_seen = 1'b0; done_v = '0;
        while (!done_seen && cycles < 300) begin
            @(posedge mclk); #1; cycles++;
            if (stall_len > 0 && cycles >= 1 && cycles < 1 + stall_len) begin
                bus_gnt = 1'b0; #1;
                check({tag, "_stall_per_en"}, 32'(per_en), 32'd0);
                check({tag, "_stall_bus_req"}, 32'(bus_req), 32'd1);
            end else begin
                bus_gnt = 1'b1; #1;
            end
            if (req_done != '0) begin
                done_seen = 1'b1;
                done_v = req_done;
                check({tag, "_err"}, 32'(rsp_err), 32'(exp_err));
                if (!wr[g]) check({tag, "_rdata"}, 32'(rsp_rdata), exp_err ? 32'd0 : 32'(d));
            end
        end
        check({tag, "_latency"}, 32'(cycles), 32'(exp_lat));
        check({tag, "_done_vec"}, 32'(done_v), 32'(1 << g));
        @(negedge mclk);
        req_valid[g] = 1'b0;
        @(posedge mclk); #1;
        check({tag, "_done_pulse_len"}, 32'(req_done), 32'd0);
        check({tag, "_status_reads"}, 32'(st_cnt - sb), 32'(exp_st));
        check({tag, "_data_reads"}, 32'(rd_cnt - rb), 32'(exp_rd));
        check({tag, "_data_writes"}, 32'(wr_cnt - wb), 32'(exp_wr));
        check({tag, "_bus_cycles"}, 32'(en_cnt - eb), 32'(exp_st + exp_rd + exp_wr));
        if (wr[g]) check({tag, "_wdin"}, 32'(wr_din), 32'({8'h00, wd[8*g +: 8]}));
        model_last = g;
        @(negedge mclk);
    endtask

    initial begin
        logic [NREQ-1:0]   rv, rw;
        logic [8*NREQ-1:0] rwd;
        puc_rst_n = 1'b0;
        req_valid = '0; req_write = '0; req_wdata = '0; bus_gnt = 1'b1;
        #1;
        check("reset_bus", 32'({per_en, bus_req, per_we}), 32'd0);
        check("reset_addr_din", 32'({per_addr, per_din}), 32'd0);
        check("reset_rsp", 32'({req_done, rsp_rdata, rsp_err}), 32'd0);
        @(negedge mclk); @(negedge mclk);
        puc_rst_n = 1'b1;
        @(negedge mclk);

        run_txn(2'b01, 2'b01, 16'h0041, 0, 8'h00, 0, "put0");
        run_txn(2'b10, 2'b00, 16'h0000, 2, 8'h5A, 0, "get1");
        // Both requesters keep asking: grants must alternate
        for (int k = 0; k < 4; k++)
            run_txn(2'b11, 2'b00, 16'h0000, 0, 8'(8'h10 + k), 0, "arb");
        run_txn(2'b01, 2'b00, 16'h0000, 13, 8'h77, 5, "stall");
        run_txn(2'b10, 2'b00, 16'h0000, 1000, 8'h99, 0, "timeout");

        // Reset in the middle of polling
        zeros = 1000; st_base = st_cnt;
        req_valid = 2'b01; req_write = 2'b00; bus_gnt = 1'b1;
        repeat (4) @(posedge mclk);
        #2;
        check("pre_reset_per_en", 32'(per_en), 32'd1);
        puc_rst_n = 1'b0;
        #1;
        check("async_reset_outs", 32'({per_en, bus_req, req_done}), 32'd0);
        @(negedge mclk);
        req_valid = '0;
        @(negedge mclk);
        puc_rst_n = 1'b1;
        model_last = NREQ - 1;
        @(negedge mclk);
        run_txn(2'b01, 2'b00, 16'h0000, 1, 8'h33, 0, "post_reset");

        for (int k = 0; k < 16; k++) begin
            rv  = NREQ'($urandom_range(1, 3));
            rw  = NREQ'($urandom_range(0, 3));
            rwd = (8*NREQ)'($urandom);
            run_txn(rv, rw, rwd, int'($urandom_range(0, 19)), 8'($urandom), 0, "rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
